led_blink_code_gen: RTL and testbench



---
 rtl/led_status_pkg.sv | 29 ++
 rtl/led_blink_code_gen_tick_prescaler.sv | 40 ++++
 rtl/led_blink_code_gen.sv | 170 +++++++++++++++++
 tb/tb_led_blink_code_gen.sv | 171 +++++++++++++++++
 4 files changed

// File: rtl/led_status_pkg.sv
// Shared types, default timing and width helpers for the LED blink-code generator.
package led_status_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_ON   = 2'd1,
    ST_OFF  = 2'd2,
    ST_GAP  = 2'd3
  } state_e;

  // 100 ms tick on the 40 MHz board clock
  localparam int DEF_TICK_DIV  = 4_000_000;
  localparam int DEF_ON_TICKS  = 2;
  localparam int DEF_OFF_TICKS = 2;
  localparam int DEF_GAP_TICKS = 10;
  localparam int DEF_ACT_TICKS = 1;

  function automatic int max3(input int a, input int b, input int c);
    int m;
    m = (a > b) ? a : b;
    return (m > c) ? m : c;
  endfunction

  // Bits needed to hold the values 0..n
  function automatic int cnt_w(input int n);
    return (n < 2) ? 1 : $clog2(n + 1);
  endfunction

endpackage

// File: rtl/led_blink_code_gen_tick_prescaler.sv
// Free-running divider producing a one-cycle tick every TICK_DIV clocks; clear restarts the period.
module tick_prescaler
  import led_status_pkg::*;
#(
  parameter int TICK_DIV = DEF_TICK_DIV
) (
  input  logic clk,
  input  logic reset,
  input  logic clear,
  output logic tick
);

  localparam int            PW   = cnt_w(TICK_DIV - 1);
  localparam logic [PW-1:0] LAST = PW'(TICK_DIV - 1);

  logic [PW-1:0] cnt_q;
  logic [PW-1:0] cnt_d;

  // Next count: wrap at the last cycle of the period or restart on clear
  always_comb begin
    cnt_d = cnt_q;
    if (clear || (cnt_q == LAST)) begin
      cnt_d = '0;
    end else begin
      cnt_d = cnt_q + PW'(1);
    end
  end

  // Counter register
  always_ff @(posedge clk) begin
    if (reset) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign tick = (cnt_q == LAST);

endmodule

// File: rtl/led_blink_code_gen.sv
// Status LED source: retriggerable activity flash in IDLE, repeating N-pulse fault code otherwise.
module led_blink_code_gen
  import led_status_pkg::*;
#(
  parameter int TICK_DIV  = DEF_TICK_DIV,
  parameter int ON_TICKS  = DEF_ON_TICKS,
  parameter int OFF_TICKS = DEF_OFF_TICKS,
  parameter int GAP_TICKS = DEF_GAP_TICKS,
  parameter int ACT_TICKS = DEF_ACT_TICKS,
  parameter int CODE_W    = 3
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [CODE_W-1:0] code_in,
  input  logic              code_load,
  input  logic              activity,
  output logic              status,
  output logic              code_active
);

  localparam int             TCW      = cnt_w(max3(ON_TICKS, OFF_TICKS, GAP_TICKS) - 1);
  localparam int             STW      = cnt_w(ACT_TICKS * TICK_DIV);
  localparam logic [STW-1:0] ACT_CYC  = STW'(ACT_TICKS * TICK_DIV);
  localparam logic [TCW-1:0] ON_LAST  = TCW'(ON_TICKS - 1);
  localparam logic [TCW-1:0] OFF_LAST = TCW'(OFF_TICKS - 1);
  localparam logic [TCW-1:0] GAP_LAST = TCW'(GAP_TICKS - 1);

  state_e              state_q, state_d;
  logic [CODE_W-1:0]   cur_code_q, cur_code_d;
  logic [CODE_W-1:0]   pend_code_q, pend_code_d;
  logic                pend_valid_q, pend_valid_d;
  logic [CODE_W-1:0]   pulse_cnt_q, pulse_cnt_d;
  logic [TCW-1:0]      tick_cnt_q, tick_cnt_d;
  logic [STW-1:0]      stretch_q, stretch_d;
  logic                status_q, status_d;
  logic                code_active_q, code_active_d;

  logic                tick;
  logic                presc_clear;
  logic [TCW-1:0]      state_last;
  logic                state_done;
  logic [CODE_W-1:0]   eff_code;

  tick_prescaler #(.TICK_DIV(TICK_DIV)) u_prescaler (
    .clk   (clk),
    .reset (reset),
    .clear (presc_clear),
    .tick  (tick)
  );

  // Final tick index of the current timed state
  always_comb begin
    state_last = ON_LAST;
    case (state_q)
      ST_ON:   state_last = ON_LAST;
      ST_OFF:  state_last = OFF_LAST;
      ST_GAP:  state_last = GAP_LAST;
      default: state_last = ON_LAST;
    endcase
  end

  assign state_done = tick && (tick_cnt_q == state_last);
  // A load coinciding with the last gap tick wins over anything already pending
  assign eff_code   = code_load ? code_in : (pend_valid_q ? pend_code_q : cur_code_q);

  // Next-state, counters, pending code and registered output values
  always_comb begin
    state_d      = state_q;
    cur_code_d   = cur_code_q;
    pulse_cnt_d  = pulse_cnt_q;
    stretch_d    = '0;
    presc_clear  = 1'b0;

    if ((state_q != ST_IDLE) && code_load) begin
      pend_code_d  = code_in;
      pend_valid_d = 1'b1;
    end else begin
      pend_code_d  = pend_code_q;
      pend_valid_d = pend_valid_q;
    end

    if (state_q == ST_IDLE) begin
      tick_cnt_d = '0;
    end else if (tick) begin
      tick_cnt_d = state_done ? '0 : (tick_cnt_q + TCW'(1));
    end else begin
      tick_cnt_d = tick_cnt_q;
    end

    case (state_q)
      ST_IDLE: begin
        if (activity) begin
          stretch_d = ACT_CYC;
        end else if (stretch_q != '0) begin
          stretch_d = stretch_q - STW'(1);
        end else begin
          stretch_d = '0;
        end
        if (code_load && (code_in != '0)) begin
          state_d     = ST_ON;
          cur_code_d  = code_in;
          pulse_cnt_d = CODE_W'(1);
          presc_clear = 1'b1;
          stretch_d   = '0;
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_ON: begin
        if (state_done) begin
          state_d = (pulse_cnt_q < cur_code_q) ? ST_OFF : ST_GAP;
        end else begin
          state_d = ST_ON;
        end
      end
      ST_OFF: begin
        if (state_done) begin
          state_d     = ST_ON;
          pulse_cnt_d = pulse_cnt_q + CODE_W'(1);
        end else begin
          state_d = ST_OFF;
        end
      end
      ST_GAP: begin
        if (state_done) begin
          pend_valid_d = 1'b0;
          pend_code_d  = '0;
          cur_code_d   = eff_code;
          pulse_cnt_d  = CODE_W'(1);
          state_d      = (eff_code != '0) ? ST_ON : ST_IDLE;
        end else begin
          state_d = ST_GAP;
        end
      end
      default: state_d = ST_IDLE;
    endcase

    code_active_d = (state_d != ST_IDLE);
    status_d      = (state_d == ST_ON) || ((state_d == ST_IDLE) && (stretch_d != '0));
  end

  // State and datapath registers
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q       <= ST_IDLE;
      cur_code_q    <= '0;
      pend_code_q   <= '0;
      pend_valid_q  <= 1'b0;
      pulse_cnt_q   <= '0;
      tick_cnt_q    <= '0;
      stretch_q     <= '0;
      status_q      <= 1'b0;
      code_active_q <= 1'b0;
    end else begin
      state_q       <= state_d;
      cur_code_q    <= cur_code_d;
      pend_code_q   <= pend_code_d;
      pend_valid_q  <= pend_valid_d;
      pulse_cnt_q   <= pulse_cnt_d;
      tick_cnt_q    <= tick_cnt_d;
      stretch_q     <= stretch_d;
      status_q      <= status_d;
      code_active_q <= code_active_d;
    end
  end

  assign status      = status_q;
  assign code_active = code_active_q;

endmodule

// File: tb/tb_led_blink_code_gen.sv
// Scoreboard bench: stimulus queues per-cycle expected outputs, a monitor pops and compares them.
`timescale 1ns/1ps
module tb_led_blink_code_gen;

  logic       clk = 1'b0;
  logic       reset;
  logic [2:0] code_in;
  logic       code_load;
  logic       activity;
  logic       status;
  logic       code_active;

  typedef struct {
    logic es;
    logic ea;
    int   sc;
    int   x;
  } exp_t;

  exp_t sb[$];
  int   vec_cnt  = 0;
  int   miss_cnt = 0;

  led_blink_code_gen #(
    .TICK_DIV (4),
    .ON_TICKS (2),
    .OFF_TICKS(2),
    .GAP_TICKS(6),
    .ACT_TICKS(3),
    .CODE_W   (3)
  ) dut (
    .clk        (clk),
    .reset      (reset),
    .code_in    (code_in),
    .code_load  (code_load),
    .activity   (activity),
    .status     (status),
    .code_active(code_active)
  );

  always #12.5 clk = ~clk;

  // Group phase p (0-based) for code n: 8-cycle pulses every 16 cycles, then gap
  function automatic logic grp_high(input int p, input int n);
    return (p < 16 * n) && ((p % 16) < 8);
  endfunction

  // Drive one cycle of inputs and queue the outputs expected after the coming edge
  task automatic drive(input logic r, input logic a, input logic l, input logic [2:0] c,
                       input logic es, input logic ea, input int sc, input int x);
    exp_t e;
    reset     = r;
    activity  = a;
    code_load = l;
    code_in   = c;
    e.es = es;
    e.ea = ea;
    e.sc = sc;
    e.x  = x;
    sb.push_back(e);
    @(negedge clk);
  endtask

  task automatic rst2(input int sc);
    drive(1'b1, 1'b0, 1'b0, 3'd0, 1'b0, 1'b0, sc, -1);
    drive(1'b1, 1'b0, 1'b0, 3'd0, 1'b0, 1'b0, sc, -1);
  endtask

  // Monitor: compare outputs just after each active edge against the queued expectation
  initial begin
    exp_t e;
    forever begin
      @(posedge clk);
      #1;
      if (sb.size() != 0) begin
        e = sb.pop_front();
        vec_cnt = vec_cnt + 1;
        if (status !== e.es) begin
          miss_cnt = miss_cnt + 1;
          $display("FAIL status sc%0d x=%0d got=%b exp=%b", e.sc, e.x, status, e.es);
        end
        vec_cnt = vec_cnt + 1;
        if (code_active !== e.ea) begin
          miss_cnt = miss_cnt + 1;
          $display("FAIL code_active sc%0d x=%0d got=%b exp=%b", e.sc, e.x, code_active, e.ea);
        end
      end
    end
  end

  // Directed scenarios; t is the input cycle, x = t+1 the cycle whose outputs are checked
  initial begin
    int x;
    logic es;
    logic ea;
    reset     = 1'b1;
    activity  = 1'b0;
    code_load = 1'b0;
    code_in   = 3'd0;
    @(negedge clk);

    // 1: reset dominates toggling strobes
    for (int t = 0; t < 5; t++)
      drive(1'b1, (t % 2) == 1, (t % 2) == 0, 3'd5, 1'b0, 1'b0, 1, t + 1);
    drive(1'b0, 1'b0, 1'b0, 3'd0, 1'b0, 1'b0, 1, 6);
    drive(1'b0, 1'b0, 1'b0, 3'd0, 1'b0, 1'b0, 1, 7);

    // 2: activity retrigger; a zero code load in IDLE does nothing
    for (int t = 0; t < 40; t++) begin
      x = t + 1;
      drive(1'b0, (t == 10) || (t == 18), t == 5, 3'd0, (x >= 11) && (x <= 30), 1'b0, 2, x);
    end

    // 3: code 3 repeating with 64-cycle period
    rst2(3);
    for (int t = 0; t < 140; t++) begin
      x = t + 1;
      drive(1'b0, 1'b0, t == 0, 3'd3, grp_high((x - 1) % 64, 3), 1'b1, 3, x);
    end

    // 4: code 1 loaded mid-group applies from the next group
    rst2(4);
    for (int t = 0; t < 140; t++) begin
      x  = t + 1;
      es = (x <= 64) ? grp_high((x - 1) % 64, 3) : grp_high((x - 65) % 32, 1);
      drive(1'b0, 1'b0, (t == 0) || (t == 20), (t == 0) ? 3'd3 : 3'd1, es, 1'b1, 4, x);
    end

    // 5: code 0 mid-group ends after the gap; activity ignored while playing, works after
    rst2(5);
    for (int t = 0; t < 90; t++) begin
      x  = t + 1;
      ea = (x <= 64);
      es = (x <= 64) ? grp_high((x - 1) % 64, 3) : ((x >= 73) && (x <= 84));
      drive(1'b0, (t == 30) || (t == 72), (t == 0) || (t == 20), (t == 0) ? 3'd3 : 3'd0,
            es, ea, 5, x);
    end

    // 6: load on the final gap tick takes effect for the very next group
    rst2(6);
    for (int t = 0; t < 100; t++) begin
      x  = t + 1;
      es = (x <= 32) ? grp_high((x - 1) % 32, 1) : grp_high((x - 33) % 48, 2);
      drive(1'b0, 1'b0, (t == 0) || (t == 32), (t == 0) ? 3'd1 : 3'd2, es, 1'b1, 6, x);
    end

    // 7: maximum code plays 7 pulses without wrap; reset during 5th pulse of group 2
    rst2(7);
    for (int t = 0; t < 226; t++) begin
      x = t + 1;
      if (x <= 195) begin
        es = grp_high((x - 1) % 128, 7);
        ea = 1'b1;
      end else begin
        es = (x >= 206) && (x <= 217);
        ea = 1'b0;
      end
      drive((t == 195) || (t == 196), t == 205, t == 0, 3'd7, es, ea, 7, x);
    end

    @(posedge clk);
    #2;
    if (sb.size() != 0) begin
      miss_cnt = miss_cnt + 1;
      $display("FAIL drain pending=%0d required=0", sb.size());
    end
    $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, miss_cnt);
    $finish;
  end

endmodule
